sdram_device_responder: RTL and testbench
=========================================

// Module: sdram_device_responder
// PURPOSE
//  Synthesizable single-rank SDR SDRAM device responder: the memory end of the sdram_wire interface driven by the
//  SoC's SDRAM controller. Decodes cs_n/ras_n/cas_n/we_n commands, tracks per-bank open rows, stores data in an
//  on-chip array and returns read data after the programmed CAS latency. Used in simulation and FPGA loopback
//  benches to exercise the rasterizer framebuffer path without a physical SDRAM. Flags protocol violations.
// PARAMETERS
//  ROW_BITS   4   stored row-address bits per bank (upper row bits ignored -> alias)
//  COL_BITS   6   stored column-address bits (sdram_wire_addr[COL_BITS-1:0]); rest ignored
//  DATA_W     32  data width; DQM width = DATA_W/8
// PORTS
//  clk_clk            in     1       sole clock; all inputs sampled on rising edge
//  reset_reset_n      in     1       asynchronous, active-low reset
//  sdram_wire_addr    in     13      row (ACT), column + A10 (RD/WR/PRE), mode (MRS)
//  sdram_wire_ba      in     2       bank select
//  sdram_wire_cs_n    in     1       chip select, low active
//  sdram_wire_ras_n   in     1       command bit
//  sdram_wire_cas_n   in     1       command bit
//  sdram_wire_we_n    in     1       command bit
//  sdram_wire_cke     in     1       clock enable; low = hold all state, ignore command
//  sdram_wire_dqm     in     4       byte mask, high = masked
//  sdram_wire_dq      inout  32      write data in; read data out, high-Z otherwise
//  err_flag           out    1       sticky: any protocol violation since reset
//  err_code           out    3       code of FIRST violation (0 none,1 no-MRS,2 ACT-open,3 RW-closed,4 bad-CL,5 bad-BL)
// BEHAVIOUR
//  Interface: one clock, clk_clk; asynchronous active-low reset reset_reset_n.
//  Reset: all banks idle, mode_valid=0, CL=3, read pipe empty, dq high-Z, err_flag=0, err_code=0. Memory array not cleared.
//  Decode {cs_n,ras_n,cas_n,we_n}: 1xxx INHIBIT, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 MRS.
//  MRS: CL=addr[6:4] (2 or 3 legal, else err 4, CL unchanged); BL=addr[2:0] must be 000 (else err 5); sets mode_valid.
//  Any ACT/READ/WRITE while mode_valid=0 -> err 1, command ignored.
//  ACT: bank open with row=addr[ROW_BITS-1:0]; ACT to open bank -> err 2, row unchanged.
//  PRE: addr[10]=1 closes all banks, else bank ba; PRE of idle bank is legal no-op. REF: no state change (no refresh check).
//  WRITE: bank must be open else err 3 and no write; word {ba,row,col} written same edge, bytes with dqm=1 untouched.
//  READ: bank must be open else err 3 and no data. Data captured from array at command edge (array bypassed by same-cycle
//   write not possible on one bus); dq driven exactly CL cycles after READ edge, for one cycle; bytes whose dqm was 1 at
//   the READ edge driven high-Z. Back-to-back READs each cycle -> back-to-back output words, no gap.
//  Read pipe is a CL-deep shift register; MRS changing CL while reads in flight: in-flight reads keep old latency.
//  WRITE while a read is due to drive dq in the same cycle: write wins, dq not driven (controller bus-turnaround bug);
//   dropped read does not set err (bench checks dq).
//  A10 on READ/WRITE (auto-precharge): bank closed after the access.
//  cke=0: command ignored, read pipe frozen, dq keeps its current drive state.
//  err_flag/err_code: set on first violation, held until reset; later violations do not overwrite err_code.
//  Reset mid-burst: read pipe flushed, dq released to high-Z asynchronously.
// STRUCTURE
//  Package sdram_cmd_pkg: cmd_e enum (7 commands + INHIBIT), err_e codes, MRS field positions, BANKS=4.
//  Sub-module sdram_read_pipe: CL-selectable (2/3) delay line carrying {valid, data, byte_oe}; drives dq tri-state.
//  Top: decoder, 4-entry bank-row table, array (2**(2+ROW_BITS+COL_BITS) x DATA_W), error logic.
// TESTING
//  MRS CL=3; ACT b0 r5; WRITE c3 0xDEADBEEF; READ c3 -> dq=0xDEADBEEF 3 cycles after READ, high-Z before/after, err_flag=0.
//  MRS CL=2; WRITE 0x11223344 dqm=0000 then 0xAABBCCDD dqm=0101 same addr; READ -> dq=0xAA22CC44 at +2.
//  READ to idle bank 2 -> err_flag=1, err_code=3, dq stays high-Z; then ACT open bank -> err_code remains 3.
//  ACT b1 twice -> err_code=2; READ with A10=1, then READ same bank -> second flagged (bank auto-closed).
//  Four READs consecutive cycles, CL=3 -> four consecutive dq words; cke=0 for 1 cycle mid-burst -> output stretches 1 cycle.
//  Assert reset_reset_n low one cycle after READ -> dq high-Z immediately, no late word after release; READ before MRS -> err 1.

Source files
------------

// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: SDR SDRAM command/error encodings and mode-register field positions.
package sdram_cmd_pkg;
  localparam int BANKS = 4;
  localparam int BA_W = 2;
  localparam int ADDR_W = 13;
  localparam int A10 = 10;
  localparam int MRS_CL_LSB = 4;
  localparam int MRS_BL_LSB = 0;
  localparam int MRS_FIELD_W = 3;
  localparam int PIPE_STAGES = 4;
  typedef enum logic [3:0] {
    CMD_MRS     = 4'b0000,
    CMD_REF     = 4'b0001,
    CMD_PRE     = 4'b0010,
    CMD_ACT     = 4'b0011,
    CMD_WRITE   = 4'b0100,
    CMD_READ    = 4'b0101,
    CMD_NOP     = 4'b0111,
    CMD_INHIBIT = 4'b1000
  } cmd_e;
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_NO_MRS    = 3'd1,
    ERR_ACT_OPEN  = 3'd2,
    ERR_RW_CLOSED = 3'd3,
    ERR_BAD_CL    = 3'd4,
    ERR_BAD_BL    = 3'd5
  } err_e;
  // Burst-terminate (0110) is not modelled and behaves as a NOP.
  function automatic cmd_e decode(input logic cs_n, input logic ras_n, input logic cas_n, input logic we_n);
    return cs_n ? CMD_INHIBIT : ({ras_n, cas_n, we_n} == 3'b110) ? CMD_NOP : cmd_e'({1'b0, ras_n, cas_n, we_n});
  endfunction
endpackage

// File: rtl/sdram_device_responder_if.sv
// sdram_device_responder_if: SDRAM command/address/mask wires between controller and device.
interface sdram_device_responder_if #(parameter int DATA_W = 32);
  import sdram_cmd_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [BA_W-1:0] ba;
  logic cs_n, ras_n, cas_n, we_n, cke;
  logic [DATA_W/8-1:0] dqm;
  modport master (output addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm);
  modport slave (input addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm);
endinterface

// File: rtl/sdram_read_pipe.sv
// sdram_read_pipe: CAS-latency delay line for read words; entries keep the latency they were issued with.
module sdram_read_pipe import sdram_cmd_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cl3,
  input  logic                push,
  input  logic                suppress,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic [DATA_W/8-1:0] byte_oe,
  output logic [DATA_W-1:0]   dout,
  output logic [DATA_W/8-1:0] oe
);
  localparam int NB = DATA_W/8;
  typedef struct packed {
    logic valid;
    logic [NB-1:0] be;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t st [PIPE_STAGES];
  ent_t fresh;
  assign fresh = '{valid: push, be: byte_oe, data: rd_data};
  // CL3 enters one stage earlier than CL2, so a later CL change never retimes queued words.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= '{default: '0};
    else if (en) begin
      st[0] <= cl3 ? fresh : '0;
      st[1] <= !cl3 && push ? fresh : st[0];
      for (int i = 2; i < PIPE_STAGES; i++) st[i] <= st[i-1];
    end
  assign dout = st[PIPE_STAGES-1].data;
  assign oe = st[PIPE_STAGES-1].valid && !suppress ? st[PIPE_STAGES-1].be : '0;
endmodule

// File: rtl/sdram_device_responder.sv
// sdram_device_responder: SDR SDRAM device model with bank-row tracking, on-chip array,
// CAS-latency read return and sticky protocol-violation reporting.
module sdram_device_responder import sdram_cmd_pkg::*; #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6,
  parameter int DATA_W = 32
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  sdram_device_responder_if.slave bus,
  inout  wire  [DATA_W-1:0]      sdram_wire_dq,
  output logic                   err_flag,
  output logic [2:0]             err_code
);
  localparam int NB = DATA_W/8;
  localparam int AW = BA_W + ROW_BITS + COL_BITS;
  cmd_e cmd;
  err_e err_now;
  logic [BANKS-1:0] open_q;
  logic [ROW_BITS-1:0] row_q [BANKS];
  logic mode_valid, cl3, bank_open, is_rw, act_ok, rd_ok, wr_ok, cl_ok, bl_ok;
  logic [MRS_FIELD_W-1:0] cl_field;
  logic [AW-1:0] idx;
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] pipe_data;
  logic [NB-1:0] pipe_oe;
  logic unused_addr;
  assign cmd = bus.cke ? decode(bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n) : CMD_NOP;
  assign bank_open = open_q[bus.ba];
  assign is_rw = cmd == CMD_READ || cmd == CMD_WRITE;
  assign act_ok = cmd == CMD_ACT && mode_valid && !bank_open;
  assign rd_ok = cmd == CMD_READ && mode_valid && bank_open;
  assign wr_ok = cmd == CMD_WRITE && mode_valid && bank_open;
  assign cl_field = bus.addr[MRS_CL_LSB +: MRS_FIELD_W];
  assign cl_ok = cl_field == 3'd2 || cl_field == 3'd3;
  assign bl_ok = bus.addr[MRS_BL_LSB +: MRS_FIELD_W] == '0;
  assign idx = {bus.ba, row_q[bus.ba], bus.addr[COL_BITS-1:0]};
  assign unused_addr = ^{bus.addr[ADDR_W-1:A10+1], bus.addr[A10-1:7]};
  assign err_now = (cmd == CMD_ACT || is_rw) && !mode_valid ? ERR_NO_MRS :
                   cmd == CMD_ACT && bank_open ? ERR_ACT_OPEN :
                   is_rw && !bank_open ? ERR_RW_CLOSED :
                   cmd == CMD_MRS && !cl_ok ? ERR_BAD_CL :
                   cmd == CMD_MRS && !bl_ok ? ERR_BAD_BL : ERR_NONE;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      open_q <= '0;
      mode_valid <= 1'b0;
      cl3 <= 1'b1;
      err_flag <= 1'b0;
      err_code <= '0;
    end else begin
      if (err_now != ERR_NONE && !err_flag) begin
        err_flag <= 1'b1;
        err_code <= err_now;
      end
      if (cmd == CMD_MRS) begin
        mode_valid <= 1'b1;
        if (cl_ok) cl3 <= cl_field[0];
      end
      if (act_ok) open_q[bus.ba] <= 1'b1;
      if (cmd == CMD_PRE && bus.addr[A10]) open_q <= '0;
      else if (cmd == CMD_PRE || ((rd_ok || wr_ok) && bus.addr[A10])) open_q[bus.ba] <= 1'b0;
    end
  // Array and open-row latches are not reset; rows are only consulted while the bank is open.
  always_ff @(posedge clk_clk) begin
    if (act_ok) row_q[bus.ba] <= bus.addr[ROW_BITS-1:0];
    if (wr_ok)
      for (int i = 0; i < NB; i++)
        if (!bus.dqm[i]) mem[idx][8*i +: 8] <= sdram_wire_dq[8*i +: 8];
  end
  sdram_read_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .en       (bus.cke),
    .cl3      (cl3),
    .push     (rd_ok),
    .suppress (cmd == CMD_WRITE),
    .rd_data  (mem[idx]),
    .byte_oe  (~bus.dqm),
    .dout     (pipe_data),
    .oe       (pipe_oe)
  );
  for (genvar b = 0; b < NB; b++) begin : g_dq
    assign sdram_wire_dq[8*b +: 8] = pipe_oe[b] ? pipe_data[8*b +: 8] : 8'bz;
  end
endmodule

// File: tb/tb_sdram_device_responder.sv
// tb_sdram_device_responder: directed scenarios against sdram_device_responder; a pullup makes a released bus read all-ones.
module tb_sdram_device_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, PRE = 4'b0010, MRS = 4'b0000;
  localparam logic [31:0] Z = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] tb_d;
  logic tb_drv;
  logic err_flag;
  logic [2:0] err_code;
  wire [31:0] dq;
  int n_chk = 0;
  int n_fail = 0;
  sdram_device_responder_if bus ();
  assign dq = tb_drv ? tb_d : 32'bz;
  pullup (dq);
  always #5 clk = ~clk;
  sdram_device_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_n),
    .bus           (bus),
    .sdram_wire_dq (dq),
    .err_flag      (err_flag),
    .err_code      (err_code)
  );

  task automatic tick(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [3:0] m, input logic [31:0] d);
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.ba = b;
    bus.addr = a;
    bus.dqm = m;
    tb_d = d;
    tb_drv = c == WR;
    @(posedge clk);
    #1;
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    bus.dqm = '0;
    tb_drv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(NOP, 2'd0, 13'd0, 4'd0, 32'd0);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    bus.ba = '0; bus.addr = '0; bus.dqm = '0; bus.cke = 1'b1;
    tb_drv = 1'b0; tb_d = '0; reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b expected 0", err_flag); end
    n_chk++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", err_code); end
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL reset_dq: got %h expected %h", dq, Z); end
  endtask

  task automatic test_no_mrs;
    tick(ACT, 2'd0, 13'd5, 4'd0, 32'd0);
    n_chk++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL nomrs_flag: got %b expected 1", err_flag); end
    n_chk++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL nomrs_code: got %0d expected 1", err_code); end
    do_reset;
  endtask

  task automatic test_basic_cl3;
    tick(MRS, 2'd0, 13'h030, 4'd0, 32'd0);
    tick(ACT, 2'd0, 13'd5, 4'd0, 32'd0);
    tick(WR, 2'd0, 13'd3, 4'd0, 32'hDEADBEEF);
    tick(RD, 2'd0, 13'd3, 4'd0, 32'd0);
    idle(2);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL cl3_early: got %h expected %h", dq, Z); end
    idle(1);
    n_chk++; if (dq !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cl3_data: got %h expected deadbeef", dq); end
    idle(1);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL cl3_late: got %h expected %h", dq, Z); end
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL cl3_err: got %b expected 0", err_flag); end
  endtask

  task automatic test_mask_cl2;
    tick(MRS, 2'd0, 13'h020, 4'd0, 32'd0);
    tick(WR, 2'd0, 13'd7, 4'b0000, 32'h11223344);
    tick(WR, 2'd0, 13'd7, 4'b0101, 32'hAABBCCDD);
    tick(RD, 2'd0, 13'd7, 4'd0, 32'd0);
    idle(1);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL cl2_early: got %h expected %h", dq, Z); end
    idle(1);
    n_chk++; if (dq !== 32'hAA22CC44) begin n_fail++; $display("FAIL wmask: got %h expected aa22cc44", dq); end
    tick(RD, 2'd0, 13'd7, 4'b0011, 32'd0);
    idle(2);
    n_chk++; if (dq !== 32'hAA22FFFF) begin n_fail++; $display("FAIL rmask: got %h expected aa22ffff", dq); end
  endtask

  task automatic test_wr_collision;
    tick(RD, 2'd0, 13'd7, 4'd0, 32'd0);
    idle(2);
    n_chk++; if (dq !== 32'hAA22CC44) begin n_fail++; $display("FAIL coll_pre: got %h expected aa22cc44", dq); end
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = WR;
    bus.ba = 2'd0; bus.addr = 13'd7; bus.dqm = '0;
    tb_d = 32'h55667788; tb_drv = 1'b1;
    #1;
    n_chk++; if (dq !== 32'h55667788) begin n_fail++; $display("FAIL coll_bus: got %h expected 55667788", dq); end
    @(posedge clk);
    #1;
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    tb_drv = 1'b0;
    tick(RD, 2'd0, 13'd7, 4'd0, 32'd0);
    idle(2);
    n_chk++; if (dq !== 32'h55667788) begin n_fail++; $display("FAIL coll_mem: got %h expected 55667788", dq); end
  endtask

  task automatic test_rw_closed;
    tick(RD, 2'd2, 13'd0, 4'd0, 32'd0);
    n_chk++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL closed_flag: got %b expected 1", err_flag); end
    n_chk++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL closed_code: got %0d expected 3", err_code); end
    idle(2);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL closed_dq: got %h expected %h", dq, Z); end
    tick(ACT, 2'd2, 13'd1, 4'd0, 32'd0);
    tick(ACT, 2'd2, 13'd1, 4'd0, 32'd0);
    n_chk++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL sticky_code: got %0d expected 3", err_code); end
  endtask

  task automatic test_act_open;
    do_reset;
    tick(MRS, 2'd0, 13'h020, 4'd0, 32'd0);
    tick(ACT, 2'd1, 13'd2, 4'd0, 32'd0);
    tick(WR, 2'd1, 13'd1, 4'd0, 32'h0BADF00D);
    tick(ACT, 2'd1, 13'd3, 4'd0, 32'd0);
    n_chk++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL actopen_flag: got %b expected 1", err_flag); end
    n_chk++; if (err_code !== 3'd2) begin n_fail++; $display("FAIL actopen_code: got %0d expected 2", err_code); end
    tick(PRE, 2'd1, 13'd0, 4'd0, 32'd0);
    tick(ACT, 2'd1, 13'd2, 4'd0, 32'd0);
    tick(RD, 2'd1, 13'd1, 4'd0, 32'd0);
    idle(2);
    n_chk++; if (dq !== 32'h0BADF00D) begin n_fail++; $display("FAIL actopen_row: got %h expected 0badf00d", dq); end
  endtask

  task automatic test_auto_pre;
    do_reset;
    tick(MRS, 2'd0, 13'h020, 4'd0, 32'd0);
    tick(ACT, 2'd1, 13'd2, 4'd0, 32'd0);
    tick(RD, 2'd1, 13'h401, 4'd0, 32'd0);
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL ap_first: got %b expected 0", err_flag); end
    idle(2);
    n_chk++; if (dq !== 32'h0BADF00D) begin n_fail++; $display("FAIL ap_data: got %h expected 0badf00d", dq); end
    tick(RD, 2'd1, 13'd1, 4'd0, 32'd0);
    n_chk++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL ap_second: got %0d expected 3", err_code); end
    idle(2);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL ap_nodata: got %h expected %h", dq, Z); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    tick(MRS, 2'd0, 13'h030, 4'd0, 32'd0);
    tick(ACT, 2'd3, 13'd4, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) tick(WR, 2'd3, 13'(i), 4'd0, 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) tick(RD, 2'd3, 13'(i), 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(1);
      n_chk++; if (dq !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, dq, 32'h1000_0000 + 32'(i)); end
    end
    idle(1);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL b2b_end: got %h expected %h", dq, Z); end
  endtask

  task automatic test_cke_stall;
    tick(RD, 2'd3, 13'd0, 4'd0, 32'd0);
    tick(RD, 2'd3, 13'd1, 4'd0, 32'd0);
    idle(2);
    n_chk++; if (dq !== 32'h1000_0000) begin n_fail++; $display("FAIL stall_w0: got %h expected 10000000", dq); end
    bus.cke = 1'b0;
    @(posedge clk);
    #1;
    bus.cke = 1'b1;
    n_chk++; if (dq !== 32'h1000_0000) begin n_fail++; $display("FAIL stall_hold: got %h expected 10000000", dq); end
    idle(1);
    n_chk++; if (dq !== 32'h1000_0001) begin n_fail++; $display("FAIL stall_w1: got %h expected 10000001", dq); end
    idle(1);
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL stall_end: got %h expected %h", dq, Z); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) tick(RD, 2'd3, 13'(i), 4'd0, 32'd0);
    n_chk++; if (dq !== 32'h1000_0000) begin n_fail++; $display("FAIL rstmid_w0: got %h expected 10000000", dq); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL rstmid_async: got %h expected %h", dq, Z); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_chk++; if (dq !== Z) begin n_fail++; $display("FAIL rstmid_flush%0d: got %h expected %h", i, dq, Z); end
    end
    n_chk++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", err_flag); end
    tick(RD, 2'd3, 13'd0, 4'd0, 32'd0);
    n_chk++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL rd_nomrs: got %0d expected 1", err_code); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_no_mrs;
    test_basic_cl3;
    test_mask_cl2;
    test_wr_collision;
    test_rw_closed;
    test_act_open;
    test_auto_pre;
    test_back_to_back;
    test_cke_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
